// File: rtl/cpu_trace_buffer.sv
// Trace capture FIFO feeding a byte serializer: each captured {pc, result}
// entry is emitted as six bytes, MSB first, under valid/ready handshaking.
module cpu_trace_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic             clr,
  input  logic [31:0]      in_pc,
  input  logic [15:0]      in_result,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [7:0]       overflow_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [47:0]      shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       ovf_q, ovf_d;
  logic [47:0]      mem_q [DEPTH];

  logic push, pop, drop;

  // Pointers carry one extra wrap bit so their difference is the fill level.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign overflow_cnt = ovf_q;

  assign pop  = (state_q == IDLE) && !empty && !clr;
  assign push = cap_en && !clr && (!full || pop);
  assign drop = cap_en && !clr && full && !pop;

  assign byte_valid = (state_q == SEND);
  assign byte_data  = byte_valid ? shift_q[47:40] : 8'h00;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_pc, in_result};
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    if (clr) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      shift_d  = '0;
      idx_d    = '0;
      ovf_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
      if (drop && (ovf_q != '1)) ovf_d = ovf_q + 8'd1;
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_d = mem_q[rd_ptr_q[AW-1:0]];
            idx_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (byte_ready) begin
            shift_d = {shift_q[39:0], 8'h00};
            if (idx_q == 3'd5) begin
              idx_d   = '0;
              state_d = IDLE;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: byte scoreboard plus directed
// checks of fill level, overflow saturation, clear and reset behaviour.
module tb_cpu_trace_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst, cap_en, clr, byte_ready;
  logic [31:0]      in_pc;
  logic [15:0]      in_result;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic [7:0]       overflow_cnt;

  always #5 clk = ~clk;

  cpu_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cap_en       (cap_en),
    .clr          (clr),
    .in_pc        (in_pc),
    .in_result    (in_result),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow_cnt (overflow_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [15:0] res;
    logic [47:0] exp;
  } vec_t;

  vec_t       vecs [8];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] sb_q [$];
  logic [7:0] mon_exp;

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [47:0] e);
    for (int k = 0; k < 6; k++) sb_q.push_back(e[47-8*k -: 8]);
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [15:0] r);
    sb_q.push_back(pc[31:24]);
    sb_q.push_back(pc[23:16]);
    sb_q.push_back(pc[15:8]);
    sb_q.push_back(pc[7:0]);
    sb_q.push_back(r[15:8]);
    sb_q.push_back(r[7:0]);
  endtask

  task automatic drain(input int max_cycles, input bit rnd_ready);
    int c = 0;
    while (sb_q.size() != 0 && c < max_cycles) begin
      if (rnd_ready) byte_ready = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    byte_ready = 1'b1;
    check("drain_done", 32'(sb_q.size()), 0);
  endtask

  task automatic fill_ready_low(input int n, input logic [31:0] base);
    byte_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_pc     = base + 32'(i);
      in_result = 16'(i);
      cap_en    = 1'b1;
      step();
    end
    cap_en = 1'b0;
  endtask

  // Handshake completes at the next rising edge; inputs are stable here.
  always @(negedge clk) begin
    if (rst && byte_valid && byte_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_byte: got %0h, expected no byte", byte_data);
      end else begin
        mon_exp = sb_q.pop_front();
        check("byte", 32'(byte_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0040_0004, 16'h1234, 48'h0040_0004_1234};
    vecs[1] = '{32'hFFFF_FFFF, 16'hFFFF, 48'hFFFF_FFFF_FFFF};
    vecs[2] = '{32'h0000_0000, 16'h0000, 48'h0000_0000_0000};
    vecs[3] = '{32'h8000_0001, 16'h8001, 48'h8000_0001_8001};
    vecs[4] = '{32'h1234_5678, 16'h9ABC, 48'h1234_5678_9ABC};
    vecs[5] = '{32'hDEAD_BEEF, 16'h0F0F, 48'hDEAD_BEEF_0F0F};
    vecs[6] = '{32'h0102_0304, 16'h0506, 48'h0102_0304_0506};
    vecs[7] = '{32'hA5A5_5A5A, 16'hC33C, 48'hA5A5_5A5A_C33C};

    rst = 1'b0; cap_en = 1'b0; clr = 1'b0; byte_ready = 1'b0;
    in_pc = '0; in_result = '0;
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(overflow_cnt), 0);
    check("rst_valid", 32'(byte_valid), 0);
    check("rst_data", 32'(byte_data), 0);
    step();
    rst = 1'b1;
    step();

    // Single capture: six consecutive valid bytes, then idle.
    byte_ready = 1'b1;
    in_pc = 32'h0040_0004; in_result = 16'h1234; cap_en = 1'b1;
    expect_entry(in_pc, in_result);
    step();
    cap_en = 1'b0;
    check("single_count", 32'(count), 1);
    check("single_valid_pre", 32'(byte_valid), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("single_valid_run", 32'(byte_valid), 1);
    end
    step();
    check("single_valid_post", 32'(byte_valid), 0);
    check("single_sb_empty", 32'(sb_q.size()), 0);
    check("single_empty", 32'(empty), 1);

    // Stall on byte index 2 (pc[15:8]).
    in_pc = 32'h0040_0004; in_result = 16'h1234; cap_en = 1'b1;
    expect_entry(in_pc, in_result);
    step();
    cap_en = 1'b0;
    step();
    step();
    step();
    byte_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 32'(byte_valid), 1);
      check("stall_data", 32'(byte_data), 32'h00);
    end
    byte_ready = 1'b1;
    drain(20, 1'b0);
    step();
    check("stall_idle", 32'(byte_valid), 0);

    // Back-to-back table captures with random backpressure.
    for (int i = 0; i < 8; i++) begin
      in_pc = vecs[i].pc; in_result = vecs[i].res; cap_en = 1'b1;
      push_bytes(vecs[i].exp);
      byte_ready = 1'($urandom_range(0, 1));
      step();
    end
    cap_en = 1'b0;
    check("table_count", 32'(count), 7);
    drain(600, 1'b1);
    step();
    check("table_empty", 32'(empty), 1);
    check("table_ovf", 32'(overflow_cnt), 0);

    // Fill with ready low: 17 accepted, last 3 dropped.
    byte_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 4; i++) begin
      in_pc = 32'hA000_0000 + 32'(i); in_result = 16'h5A00 + 16'(i); cap_en = 1'b1;
      if (i < int'(DEPTH) + 1) expect_entry(in_pc, in_result);
      step();
    end
    cap_en = 1'b0;
    check("fill_count", 32'(count), DEPTH);
    check("fill_full", 32'(full), 1);
    check("fill_ovf", 32'(overflow_cnt), 3);
    check("fill_valid", 32'(byte_valid), 1);
    check("fill_data", 32'(byte_data), 32'hA0);

    // Full FIFO, serializer returns to IDLE; capture on the popping edge.
    byte_ready = 1'b1;
    begin
      int c = 0;
      while (byte_valid && c < 20) begin
        step();
        c++;
      end
    end
    check("full_idle_reached", 32'(byte_valid), 0);
    check("full_idle_count", 32'(count), DEPTH);
    in_pc = 32'hBEEF_0001; in_result = 16'hC0DE; cap_en = 1'b1;
    expect_entry(in_pc, in_result);
    step();
    cap_en = 1'b0;
    check("pushpop_count", 32'(count), DEPTH);
    check("pushpop_full", 32'(full), 1);
    check("pushpop_ovf", 32'(overflow_cnt), 3);
    check("pushpop_valid", 32'(byte_valid), 1);
    drain(200, 1'b0);
    step();
    check("pushpop_empty", 32'(empty), 1);

    // Overflow saturation.
    fill_ready_low(int'(DEPTH) + 1 + 300, 32'h3000_0000);
    check("sat_ovf", 32'(overflow_cnt), 255);
    check("sat_count", 32'(count), DEPTH);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_ovf", 32'(overflow_cnt), 0);
    check("clr_count", 32'(count), 0);
    check("clr_valid", 32'(byte_valid), 0);

    // Asynchronous reset mid-transfer with 5 entries queued.
    fill_ready_low(6, 32'h6000_0000);
    step();
    check("prerst_count", 32'(count), 5);
    check("prerst_valid", 32'(byte_valid), 1);
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(byte_valid), 0);
    check("arst_count", 32'(count), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_data", 32'(byte_data), 0);
    step();
    rst = 1'b1;
    byte_ready = 1'b1;
    in_pc = 32'hCAFE_F00D; in_result = 16'h7777; cap_en = 1'b1;
    expect_entry(in_pc, in_result);
    step();
    cap_en = 1'b0;
    drain(30, 1'b0);

    // Synchronous clear mid-transfer.
    fill_ready_low(6, 32'h7000_0000);
    step();
    check("preclr_valid", 32'(byte_valid), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("sclr_valid", 32'(byte_valid), 0);
    check("sclr_count", 32'(count), 0);
    byte_ready = 1'b1;
    in_pc = 32'h1357_9BDF; in_result = 16'h2468; cap_en = 1'b1;
    expect_entry(in_pc, in_result);
    step();
    cap_en = 1'b0;
    drain(30, 1'b0);
    step();
    check("final_idle", 32'(byte_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
